acp_job_sequencer: RTL and testbench

//  Copy-job scheduler for the ACP datamover. Host queues jobs {src, dst, len} over the register page (set/get bus).
//  For each job it issues one MM2S and one S2MM 72-bit datamover command and retires the job on both status beats.
//  It then raises irq. Sits between axi4_lite_slave and xlnx_axi_datamover; replaces the two per-direction stream masters.

---
 rtl/acp_pkg.sv | 58 +++++
 rtl/acp_job_fifo.sv | 60 ++++++
 rtl/acp_job_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_acp_job_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acp_pkg.sv
// rtl/acp_pkg.sv - shared constants, types and command packing for the ACP job sequencer
package acp_pkg;

   localparam logic [2:0] REG_SRC      = 3'd0;
   localparam logic [2:0] REG_DST      = 3'd1;
   localparam logic [2:0] REG_LEN      = 3'd2;
   localparam logic [2:0] REG_CTRL     = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;
   localparam logic [2:0] REG_LAST_STS = 3'd5;

   localparam int CTRL_IRQ_EN   = 0;
   localparam int CTRL_DONE_IRQ = 1;
   localparam int CTRL_ERR      = 2;
   localparam int CTRL_FLUSH    = 3;

   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_BUSY      = 12;
   localparam int ST_ERR       = 13;
   localparam int ST_OVF       = 14;
   localparam int ST_IRQ       = 15;

   localparam int STS_OKAY = 7;

   localparam int BTT_W        = 23;
   localparam int TAG_W        = 4;
   localparam int CMD_W        = 72;
   localparam int CMD_INCR     = 23;
   localparam int CMD_EOF      = 30;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_TAG_LSB  = 64;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0]      src;
      logic [31:0]      dst;
      logic [BTT_W-1:0] btt;
   } job_t;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic [BTT_W-1:0] btt,
                                                 input logic [31:0]      addr,
                                                 input logic [TAG_W-1:0] tag);
      logic [CMD_W-1:0] cmd;
      cmd                         = '0;
      cmd[BTT_W-1:0]              = btt;
      cmd[CMD_INCR]               = 1'b1;
      cmd[CMD_EOF]                = 1'b1;
      cmd[CMD_ADDR_LSB +: 32]     = addr;
      cmd[CMD_TAG_LSB +: TAG_W]   = tag;
      return cmd;
   endfunction

endpackage

// File: rtl/acp_job_fifo.sv
// rtl/acp_job_fifo.sv - synchronous job queue with level/full/empty and flush
module acp_job_fifo #(
   parameter int W    = 87,
   parameter int LOG2 = 2
) (
   input  logic          clk,
   input  logic          aresetn,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic [W-1:0]  pop_data_o,
   output logic [LOG2:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int DEPTH = 1 << LOG2;

   logic [W-1:0]    mem_q [DEPTH];
   logic [LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOG2:0]   level_q;
   logic            do_push, do_pop;

   assign full_o     = (level_q == (LOG2+1)'(DEPTH));
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // A push into a full queue is fine when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + LOG2'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + LOG2'(1);
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + (LOG2+1)'(1);
         end else if (do_pop && !do_push) begin
            level_q <= level_q - (LOG2+1)'(1);
         end
      end
   end

endmodule

// File: rtl/acp_job_sequencer.sv
// rtl/acp_job_sequencer.sv - queues copy jobs and drives MM2S/S2MM datamover command and status streams
module acp_job_sequencer
   import acp_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_JOB_FIFO_LOG2    = 2,
   parameter int C_HALT_ON_ERR      = 1
) (
   input  logic                          clk,
   input  logic                          aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
   input  logic                          set_stb,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
   input  logic                          get_stb,
   output logic                          mm2s_cmd_tvalid,
   input  logic                          mm2s_cmd_tready,
   output logic [CMD_W-1:0]              mm2s_cmd_tdata,
   input  logic                          mm2s_sts_tvalid,
   output logic                          mm2s_sts_tready,
   input  logic [7:0]                    mm2s_sts_tdata,
   output logic                          s2mm_cmd_tvalid,
   input  logic                          s2mm_cmd_tready,
   output logic [CMD_W-1:0]              s2mm_cmd_tdata,
   input  logic                          s2mm_sts_tvalid,
   output logic                          s2mm_sts_tready,
   input  logic [7:0]                    s2mm_sts_tdata,
   output logic                          irq,
   output logic                          busy
);

   state_t state_q, state_d;

   logic [31:0]      src_q, dst_q;
   logic [BTT_W-1:0] len_q;
   logic             irq_en_q, done_irq_q, err_q, ovf_q;
   logic             irq_en_d, done_irq_d, err_d, ovf_d;
   logic [7:0]       jobs_done_q, last_sts_q;
   logic [7:0]       jobs_done_d, last_sts_d;
   logic [TAG_W-1:0] tag_q, act_tag_q;
   job_t             act_job_q;
   logic             mm2s_acc_q, s2mm_acc_q, mm2s_seen_q, s2mm_seen_q;
   logic [7:0]       mm2s_sts_q, s2mm_sts_q;

   logic [31:0]          wdata;
   logic                 wr_src, wr_dst, wr_len, wr_ctrl;
   logic                 len_zero, push, pop, flush, ovf_set, halted;
   logic                 fifo_full, fifo_empty;
   logic [C_JOB_FIFO_LOG2:0] fifo_level;
   job_t                 fifo_head;
   logic                 mm2s_cmd_hs, s2mm_cmd_hs, mm2s_cap, s2mm_cap;
   logic                 mm2s_bad, s2mm_bad, in_done;
   logic [31:0]          status_w, rdata;

   wire unused_ok = ^{set_addr, get_addr, set_data, get_stb};

   assign wdata   = set_data[31:0];
   assign wr_src  = set_stb && (set_addr[4:2] == REG_SRC);
   assign wr_dst  = set_stb && (set_addr[4:2] == REG_DST);
   assign wr_len  = set_stb && (set_addr[4:2] == REG_LEN);
   assign wr_ctrl = set_stb && (set_addr[4:2] == REG_CTRL);

   assign halted   = err_q && (C_HALT_ON_ERR != 0);
   assign pop      = (state_q == S_IDLE) && !fifo_empty && !halted;
   assign len_zero = wr_len && (wdata[BTT_W-1:0] == '0);
   assign push     = wr_len && !len_zero && (!fifo_full || pop);
   assign ovf_set  = wr_len && !len_zero && fifo_full && !pop;
   assign flush    = wr_ctrl && wdata[CTRL_FLUSH];

   acp_job_fifo #(
      .W    ($bits(job_t)),
      .LOG2 (C_JOB_FIFO_LOG2)
   ) u_fifo (
      .clk         (clk),
      .aresetn     (aresetn),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i ({src_q, dst_q, wdata[BTT_W-1:0]}),
      .pop_i       (pop),
      .pop_data_o  (fifo_head),
      .level_o     (fifo_level),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign mm2s_cmd_hs = mm2s_cmd_tvalid && mm2s_cmd_tready;
   assign s2mm_cmd_hs = s2mm_cmd_tvalid && s2mm_cmd_tready;
   assign mm2s_cap    = mm2s_sts_tvalid && mm2s_sts_tready && !mm2s_seen_q;
   assign s2mm_cap    = s2mm_sts_tvalid && s2mm_sts_tready && !s2mm_seen_q;

   assign mm2s_cmd_tdata = pack_cmd(act_job_q.btt, act_job_q.src, act_tag_q);
   assign s2mm_cmd_tdata = pack_cmd(act_job_q.btt, act_job_q.dst, act_tag_q);

   // Status check runs on the captured beats; a wrong tag counts as an error even when OKAY.
   assign mm2s_bad = !mm2s_sts_q[STS_OKAY] || (mm2s_sts_q[TAG_W-1:0] != act_tag_q);
   assign s2mm_bad = !s2mm_sts_q[STS_OKAY] || (s2mm_sts_q[TAG_W-1:0] != act_tag_q);
   assign in_done  = (state_q == S_DONE);

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pop) state_d = S_ISSUE;
         S_ISSUE: if ((mm2s_acc_q || mm2s_cmd_hs) && (s2mm_acc_q || s2mm_cmd_hs)) state_d = S_WAIT;
         S_WAIT:  if (mm2s_seen_q && s2mm_seen_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mm2s_cmd_tvalid = 1'b0;
      s2mm_cmd_tvalid = 1'b0;
      mm2s_sts_tready = 1'b0;
      s2mm_sts_tready = 1'b0;
      if (state_q == S_ISSUE) begin
         mm2s_cmd_tvalid = !mm2s_acc_q;
         s2mm_cmd_tvalid = !s2mm_acc_q;
      end
      if (state_q == S_ISSUE || state_q == S_WAIT) begin
         mm2s_sts_tready = 1'b1;
         s2mm_sts_tready = 1'b1;
      end
      busy = (state_q != S_IDLE) || !fifo_empty;
   end

   // Sets are applied after clears so a same-cycle event wins over W1C.
   always_comb begin
      irq_en_d    = wr_ctrl ? wdata[CTRL_IRQ_EN] : irq_en_q;
      done_irq_d  = done_irq_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      jobs_done_d = jobs_done_q;
      last_sts_d  = last_sts_q;
      if (wr_ctrl && wdata[CTRL_DONE_IRQ]) done_irq_d = 1'b0;
      if (wr_ctrl && wdata[CTRL_ERR]) begin
         err_d = 1'b0;
         ovf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (len_zero) err_d = 1'b1;
      if (in_done) begin
         done_irq_d  = 1'b1;
         jobs_done_d = jobs_done_q + 8'd1;
         last_sts_d  = (mm2s_bad && !s2mm_bad) ? mm2s_sts_q : s2mm_sts_q;
         if (mm2s_bad || s2mm_bad) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         irq_en_q    <= 1'b0;
         done_irq_q  <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         jobs_done_q <= '0;
         last_sts_q  <= '0;
         tag_q       <= '0;
         act_tag_q   <= '0;
         act_job_q   <= '0;
         mm2s_acc_q  <= 1'b0;
         s2mm_acc_q  <= 1'b0;
         mm2s_seen_q <= 1'b0;
         s2mm_seen_q <= 1'b0;
         mm2s_sts_q  <= '0;
         s2mm_sts_q  <= '0;
      end else begin
         if (wr_src) src_q <= wdata;
         if (wr_dst) dst_q <= wdata;
         if (wr_len) len_q <= wdata[BTT_W-1:0];
         irq_en_q    <= irq_en_d;
         done_irq_q  <= done_irq_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         jobs_done_q <= jobs_done_d;
         last_sts_q  <= last_sts_d;
         if (pop) begin
            act_job_q   <= fifo_head;
            act_tag_q   <= tag_q;
            tag_q       <= tag_q + TAG_W'(1);
            mm2s_acc_q  <= 1'b0;
            s2mm_acc_q  <= 1'b0;
            mm2s_seen_q <= 1'b0;
            s2mm_seen_q <= 1'b0;
         end else begin
            if (mm2s_cmd_hs) mm2s_acc_q <= 1'b1;
            if (s2mm_cmd_hs) s2mm_acc_q <= 1'b1;
            if (mm2s_cap) begin
               mm2s_seen_q <= 1'b1;
               mm2s_sts_q  <= mm2s_sts_tdata;
            end
            if (s2mm_cap) begin
               s2mm_seen_q <= 1'b1;
               s2mm_sts_q  <= s2mm_sts_tdata;
            end
         end
      end
   end

   assign irq = irq_en_q && (done_irq_q || err_q);

   always_comb begin
      status_w                      = '0;
      status_w[7:0]                 = jobs_done_q;
      status_w[ST_LEVEL_LSB +: 4]   = 4'(fifo_level);
      status_w[ST_BUSY]             = busy;
      status_w[ST_ERR]              = err_q;
      status_w[ST_OVF]              = ovf_q;
      status_w[ST_IRQ]              = irq;
   end

   always_comb begin
      rdata = '0;
      case (get_addr[4:2])
         REG_SRC:      rdata = src_q;
         REG_DST:      rdata = dst_q;
         REG_LEN:      rdata = {{(32-BTT_W){1'b0}}, len_q};
         REG_CTRL: begin
            rdata[CTRL_IRQ_EN]   = irq_en_q;
            rdata[CTRL_DONE_IRQ] = done_irq_q;
            rdata[CTRL_ERR]      = err_q;
         end
         REG_STATUS:   rdata = status_w;
         REG_LAST_STS: rdata = {24'b0, last_sts_q};
         default:      rdata = '0;
      endcase
   end

   assign get_data = C_S_AXI_DATA_WIDTH'(rdata);

endmodule

// File: tb/tb_acp_job_sequencer.sv
// tb/tb_acp_job_sequencer.sv - directed self-checking bench for acp_job_sequencer
module tb_acp_job_sequencer;

   localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
   localparam logic [31:0] A_CTRL = 32'h0C, A_STATUS = 32'h10, A_LAST = 32'h14;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] set_addr, set_data, get_addr, get_data;
   logic        set_stb, get_stb;
   logic        mm2s_cmd_tvalid, mm2s_cmd_tready, s2mm_cmd_tvalid, s2mm_cmd_tready;
   logic [71:0] mm2s_cmd_tdata, s2mm_cmd_tdata;
   logic        mm2s_sts_tvalid, mm2s_sts_tready, s2mm_sts_tvalid, s2mm_sts_tready;
   logic [7:0]  mm2s_sts_tdata, s2mm_sts_tdata;
   logic        irq, busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   acp_job_sequencer dut (
      .clk(clk), .aresetn(aresetn),
      .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
      .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
      .mm2s_cmd_tvalid(mm2s_cmd_tvalid), .mm2s_cmd_tready(mm2s_cmd_tready), .mm2s_cmd_tdata(mm2s_cmd_tdata),
      .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready), .mm2s_sts_tdata(mm2s_sts_tdata),
      .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready), .s2mm_cmd_tdata(s2mm_cmd_tdata),
      .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready), .s2mm_sts_tdata(s2mm_sts_tdata),
      .irq(irq), .busy(busy)
   );

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      set_addr = a; set_data = d; set_stb = 1'b1;
      @(posedge clk); #1;
      set_stb = 1'b0;
   endtask

   task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
      get_addr = a; get_stb = 1'b1;
      #1;
      d = get_data;
      get_stb = 1'b0;
   endtask

   task automatic wait_cmd(input string tag);
      int n = 0;
      while (!mm2s_cmd_tvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, mm2s_cmd_tvalid, 1);
   endtask

   task automatic send_sts(input logic [7:0] m, input logic [7:0] s);
      int n = 0;
      mm2s_sts_tdata = m; s2mm_sts_tdata = s;
      mm2s_sts_tvalid = 1'b1; s2mm_sts_tvalid = 1'b1;
      while (!(mm2s_sts_tready && s2mm_sts_tready) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("sts_ready", {mm2s_sts_tready, s2mm_sts_tready}, 2'b11);
      @(posedge clk); #1;
      mm2s_sts_tvalid = 1'b0; s2mm_sts_tvalid = 1'b0;
   endtask

   task automatic wait_done(input logic [7:0] n_exp);
      logic [31:0] st;
      int n = 0;
      reg_rd(A_STATUS, st);
      while (st[7:0] != n_exp && n < 40) begin
         @(posedge clk); #1;
         reg_rd(A_STATUS, st);
         n++;
      end
      chk("jobs_done", st[7:0], n_exp);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [71:0] d0;
      aresetn = 1'b0; set_addr = '0; set_data = '0; set_stb = 1'b0;
      get_addr = '0; get_stb = 1'b0;
      mm2s_cmd_tready = 1'b1; s2mm_cmd_tready = 1'b1;
      mm2s_sts_tvalid = 1'b0; s2mm_sts_tvalid = 1'b0;
      mm2s_sts_tdata = '0; s2mm_sts_tdata = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_streams", {mm2s_cmd_tvalid, s2mm_cmd_tvalid, mm2s_sts_tready, s2mm_sts_tready}, 4'b0000);
      chk("rst_irq_busy", {irq, busy}, 2'b00);
      reg_rd(A_STATUS, rd);
      chk("rst_status", rd, 32'h0);
      aresetn = 1'b1;

      // single job, 2-cycle latency, command packing
      reg_wr(A_SRC, 32'h1000);
      reg_wr(A_DST, 32'h2000);
      reg_wr(A_CTRL, 32'h1);
      reg_wr(A_LEN, 32'd64);
      chk("lat_cycle1", mm2s_cmd_tvalid, 0);
      chk("busy_queued", busy, 1);
      @(posedge clk); #1;
      chk("lat_cycle2", {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b11);
      chk("mm2s_cmd", mm2s_cmd_tdata, {8'h00, 32'h00001000, 32'h40800040});
      chk("s2mm_cmd", s2mm_cmd_tdata, {8'h00, 32'h00002000, 32'h40800040});
      @(posedge clk); #1;
      chk("cmd_accepted", {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b00);
      send_sts(8'h80, 8'h80);
      wait_done(8'd1);
      chk("irq_done", irq, 1);
      reg_rd(A_LAST, rd);
      chk("last_sts_ok", rd, 32'h80);
      reg_wr(A_CTRL, 32'h3);
      chk("irq_cleared", irq, 0);

      // LEN=0 error, halt, fill queue, overflow, release
      do_reset();
      mm2s_cmd_tready = 1'b0; s2mm_cmd_tready = 1'b0;
      reg_wr(A_CTRL, 32'h1);
      reg_wr(A_LEN, 32'd0);
      reg_rd(A_STATUS, rd);
      chk("len0_status", rd, 32'h0000A000);
      chk("len0_irq", irq, 1);
      reg_wr(A_SRC, 32'h3000);
      reg_wr(A_DST, 32'h4000);
      for (int i = 0; i < 5; i++) reg_wr(A_LEN, 32'(16 * (i + 1)));
      reg_rd(A_STATUS, rd);
      chk("full_ovf_status", rd, 32'h0000F400);
      mm2s_cmd_tready = 1'b1; s2mm_cmd_tready = 1'b1;
      reg_wr(A_CTRL, 32'h5);
      for (int i = 0; i < 4; i++) begin
         wait_cmd("q_cmd_valid");
         chk("q_mm2s_cmd", mm2s_cmd_tdata, {4'h0, 4'(i), 32'h00003000, 32'h40800000 | 32'(16 * (i + 1))});
         send_sts(8'h80 | 8'(i), 8'h80 | 8'(i));
         wait_done(8'(i + 1));
      end
      reg_rd(A_STATUS, rd);
      chk("drained_status", rd, 32'h00008004);

      // MM2S command held off, S2MM accepted immediately
      mm2s_cmd_tready = 1'b0;
      reg_wr(A_LEN, 32'd128);
      @(posedge clk); #1;
      chk("hold_both_valid", {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b11);
      d0 = mm2s_cmd_tdata;
      chk("hold_mm2s_cmd", d0, {4'h0, 4'h4, 32'h00003000, 32'h40800080});
      @(posedge clk); #1;
      chk("hold_split", {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b10);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", mm2s_cmd_tvalid, 1);
         chk("hold_stable", mm2s_cmd_tdata, d0);
      end
      mm2s_cmd_tready = 1'b1;
      @(posedge clk); #1;
      chk("hold_released", {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b00);
      send_sts(8'h84, 8'h84);
      wait_done(8'd5);

      // SLVERR halts scheduling until err is cleared
      do_reset();
      reg_wr(A_CTRL, 32'h1);
      reg_wr(A_SRC, 32'h5000);
      reg_wr(A_DST, 32'h6000);
      reg_wr(A_LEN, 32'd32);
      reg_wr(A_LEN, 32'd48);
      send_sts(8'h80, 8'h40);
      wait_done(8'd1);
      reg_rd(A_STATUS, rd);
      chk("halt_status", rd, 32'h0000B101);
      reg_rd(A_LAST, rd);
      chk("halt_last_sts", rd, 32'h40);
      repeat (3) @(posedge clk);
      #1;
      chk("halt_no_pop", {mm2s_cmd_tvalid, irq}, 2'b01);
      reg_wr(A_CTRL, 32'h7);
      wait_cmd("resume_valid");
      chk("resume_cmd", mm2s_cmd_tdata, {4'h0, 4'h1, 32'h00005000, 32'h40800030});
      send_sts(8'h81, 8'h81);
      wait_done(8'd2);

      // tag mismatch and LEN=0 errors
      reg_wr(A_LEN, 32'd16);
      wait_cmd("tag2_valid");
      chk("tag2_field", mm2s_cmd_tdata[67:64], 4'h2);
      send_sts(8'h82, 8'h83);
      wait_done(8'd3);
      reg_rd(A_LAST, rd);
      chk("tagerr_last_sts", rd, 32'h83);
      reg_rd(A_STATUS, rd);
      chk("tagerr_status", rd, 32'h0000A003);
      reg_wr(A_CTRL, 32'h7);
      reg_rd(A_STATUS, rd);
      chk("err_cleared", rd, 32'h00000003);
      reg_wr(A_LEN, 32'd0);
      reg_rd(A_STATUS, rd);
      chk("len0_again", rd, 32'h0000A003);
      reg_wr(A_CTRL, 32'h5);

      // reset in WAIT abandons the job
      reg_wr(A_LEN, 32'd16);
      wait_cmd("wait_valid");
      @(posedge clk); #1;
      chk("in_wait", {mm2s_cmd_tvalid, s2mm_cmd_tvalid, mm2s_sts_tready, s2mm_sts_tready}, 4'b0011);
      aresetn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_streams", {mm2s_cmd_tvalid, s2mm_cmd_tvalid, mm2s_sts_tready, s2mm_sts_tready}, 4'b0000);
      chk("midrst_irq", irq, 0);
      reg_rd(A_STATUS, rd);
      chk("midrst_status", rd, 32'h0);
      aresetn = 1'b1;
      reg_wr(A_LEN, 32'd16);
      wait_cmd("post_rst_valid");
      chk("post_rst_cmd", mm2s_cmd_tdata, {8'h00, 32'h00000000, 32'h40800010});
      send_sts(8'h80, 8'h80);
      wait_done(8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
